// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants for the nibble-serial adder: FSM encoding and slice width.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/nibble_serial_adder_slice.sv
// Combinational 4-bit ripple-carry adder; the only arithmetic in the serial adder.
module nibble_adder_slice
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);

    logic [NIBBLE_W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < NIBBLE_W; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign co = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Adds two WIDTH-bit operands one nibble per clock through a single 4-bit slice.
// Results are registered on the last nibble and held until the next completion.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             overflow_o
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] op_a_q,   op_a_d;
    logic [WIDTH-1:0] op_b_q,   op_b_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic             carry_q,  carry_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;

    logic [NIBBLE_W-1:0] nib_a, nib_b, slice_s;
    logic                slice_co;
    logic [WIDTH-1:0]    acc_wr;

    assign nib_a  = NIBBLE_W'(op_a_q >> (NIBBLE_W * idx_q));
    assign nib_b  = NIBBLE_W'(op_b_q >> (NIBBLE_W * idx_q));
    // acc is cleared at start, so OR-ing the new nibble into place is a write
    assign acc_wr = acc_q | (WIDTH'(slice_s) << (NIBBLE_W * idx_q));

    nibble_adder_slice u_slice (
        .x  (nib_a),
        .y  (nib_b),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            RUN: begin
                acc_d   = acc_wr;
                carry_d = slice_co;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDX_W'(NIB - 1)) begin
                    state_d = DONE;
                    sum_d   = acc_wr;
                    cout_d  = slice_co;
                    ovf_d   = (nib_a[3] ^ nib_b[3] ^ slice_s[3]) ^ slice_co;
                    done_d  = 1'b1;
                end
            end
            default: begin
                // IDLE and DONE both accept a new request, giving zero-bubble issue
                if (start_i) begin
                    state_d = RUN;
                    op_a_d  = a_i;
                    op_b_d  = b_i;
                    carry_d = cin_i;
                    idx_d   = '0;
                    acc_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign sum_o      = sum_q;
    assign cout_o     = cout_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed checks on a 16-bit adder plus a reference-sum sweep on 4- and 32-bit builds.
module tb_nibble_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start16 = 1'b0, cin16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0, sum16;
    logic        busy16, done16, cout16, ovf16;

    logic        start_w = 1'b0, cin4 = 1'b0, cin32 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0, sum4;
    logic [31:0] a32 = '0, b32 = '0, sum32;
    logic        busy4, done4, cout4, ovf4, busy32, done32, cout32, ovf32;

    int n_tests = 0;
    int n_fail  = 0;

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk_i(clk), .rst_i(rst), .start_i(start16), .a_i(a16), .b_i(b16), .cin_i(cin16),
        .busy_o(busy16), .done_o(done16), .sum_o(sum16), .cout_o(cout16), .overflow_o(ovf16));

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start_w), .a_i(a4), .b_i(b4), .cin_i(cin4),
        .busy_o(busy4), .done_o(done4), .sum_o(sum4), .cout_o(cout4), .overflow_o(ovf4));

    nibble_serial_adder #(.WIDTH(32)) dut32 (
        .clk_i(clk), .rst_i(rst), .start_i(start_w), .a_i(a32), .b_i(b32), .cin_i(cin32),
        .busy_o(busy32), .done_o(done32), .sum_o(sum32), .cout_o(cout32), .overflow_o(ovf32));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic ci, input logic [15:0] es, input logic ec, input logic eo);
        logic [15:0] prev;
        int n;
        prev = sum16;
        @(negedge clk);
        a16 = av; b16 = bv; cin16 = ci; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        n = 0;
        while (!done16 && n < 20) begin
            chk({tag, " busy"}, 64'(busy16), 64'd1);
            chk({tag, " hold"}, 64'(sum16), 64'(prev));
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'd4);
        chk({tag, " sum"},     64'(sum16),  64'(es));
        chk({tag, " cout"},    64'(cout16), 64'(ec));
        chk({tag, " ovf"},     64'(ovf16),  64'(eo));
        chk({tag, " busy_end"}, 64'(busy16), 64'd0);
        @(negedge clk);
        chk({tag, " done_1cyc"}, 64'(done16), 64'd0);
    endtask

    initial begin
        logic [15:0] ca, cb;
        logic [4:0]  e4;
        logic [32:0] e32;
        int n;

        #12;
        chk("rst busy", 64'(busy16), 64'd0);
        chk("rst done", 64'(done16), 64'd0);
        chk("rst sum",  64'(sum16),  64'd0);
        chk("rst cout", 64'(cout16), 64'd0);
        chk("rst ovf",  64'(ovf16),  64'd0);
        @(negedge clk);
        rst = 1'b0;

        run16("ffff+1",    16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run16("7fff+1",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run16("8000+8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        run16("1234+4321", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
        run16("7fff+0+c",  16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);

        // start held high: captures at edges 0, 5, 10; completions after edges 4, 9, 14
        for (int k = 0; k < 15; k++) begin
            a16 = 16'h1111 * 16'(k);
            b16 = 16'h0101 + 16'(k);
            cin16 = 1'b0;
            start16 = 1'b1;
            @(negedge clk);
            chk("stream done", 64'(done16), 64'((k % 5) == 4));
            if ((k % 5) == 4) begin
                ca = 16'h1111 * 16'(k - 4);
                cb = 16'h0101 + 16'(k - 4);
                chk("stream sum", 64'(sum16), 64'(ca + cb));
            end else begin
                chk("stream busy", 64'(busy16), 64'd1);
            end
        end
        start16 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("stream idle", 64'(busy16), 64'd0);

        // abandon an addition after two nibbles
        a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst busy", 64'(busy16), 64'd0);
        chk("arst done", 64'(done16), 64'd0);
        chk("arst sum",  64'(sum16),  64'd0);
        chk("arst cout", 64'(cout16), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done16) n++;
        end
        chk("arst no_done", 64'(n), 64'd0);
        run16("after_rst", 16'h00F0, 16'h0F10, 1'b0, 16'h1000, 1'b0, 1'b0);

        for (int v = 0; v < 1000; v++) begin
            @(negedge clk);
            a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
            a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom);
            if (v == 0) begin a32 = 32'hFFFF_FFFF; b32 = 32'h0; cin32 = 1'b1; end
            if (v == 1) begin a4 = 4'h7; b4 = 4'h0; cin4 = 1'b1; end
            start_w = 1'b1;
            @(negedge clk);
            start_w = 1'b0;
            n = 0;
            while (!done32 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("w32 latency", 64'(n), 64'd8);
            e4  = {1'b0, a4} + {1'b0, b4} + {4'd0, cin4};
            e32 = {1'b0, a32} + {1'b0, b32} + {32'd0, cin32};
            chk("w4 sum",  64'({cout4, sum4}), 64'(e4));
            chk("w4 ovf",  64'(ovf4), 64'((a4[3] == b4[3]) && (e4[3] != a4[3])));
            chk("w32 sum", 64'({cout32, sum32}), 64'(e32));
            chk("w32 ovf", 64'(ovf32), 64'((a32[31] == b32[31]) && (e32[31] != a32[31])));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Sequential controller that adds two WIDTH-bit operands four bits per clock, using one combinational 4-bit ripple-carry slice.
- Sits directly upstream of the 4-bit adder slice. It slices the operands into nibbles, feeds nibble/carry pairs to the slice, and captures the slice's sum nibble and carry-out into a result register.
- Trades latency for area: a wide add costs one 4-bit slice plus registers instead of a full-width adder.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIB (localparam), WIDTH/4, nibble count and number of compute cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new addition; sampled on rising clk edges.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- cin  input  1  carry into bit 0; sampled with start.
- busy  output  1  high while nibbles are being computed.
- done  output  1  one-cycle pulse when sum/cout/overflow are updated.
- sum  output  WIDTH  registered result; holds its value until the next completion.
- cout  output  1  registered carry out of bit WIDTH-1.
- overflow  output  1  registered two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE; busy, done, sum, cout and overflow all 0.
  - Internal operand, accumulator, carry and index registers cleared.
  - Reset asserted mid-operation abandons the addition; no done is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE: if start=1, latch a, b and cin (cin goes into the carry register); clear idx and the accumulator; go to RUN. Otherwise stay.
  - RUN: on each edge:
    - feed the slice opA[4*idx+3:4*idx], opB[same], carry;
    - write the slice sum into acc[4*idx+3:4*idx];
    - carry <= slice cout;
    - idx <= idx+1.
  - RUN exit: on the edge where idx = NIB-1, go to DONE and register the results:
    - sum <= final acc, including the nibble written this edge;
    - cout <= slice cout;
    - overflow <= (carry into bit WIDTH-1) XOR slice cout. Carry into bit WIDTH-1 = a3^b3^s3 of the top nibble.
    - done <= 1.
  - DONE: done=1 for exactly this cycle. If start=1, behave exactly as IDLE with start (back-to-back, zero bubble). Otherwise go to IDLE.
- Outputs:
  - busy = 1 iff state == RUN (registered).
  - done clears on the next edge unless another completion occurs.
- Latency: done rises on the NIB-th rising edge after the edge that samples start. Issue interval is NIB+1 cycles.
- start while in RUN is ignored; operand registers are not disturbed.
- sum, cout and overflow change only on a completion edge or reset; they are stable while busy.
- Arithmetic: unsigned modulo 2^WIDTH. {cout,sum} = a+b+cin exactly.
- WIDTH=4: RUN lasts one cycle; idx width is max(1, clog2(NIB)).

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - NIBBLE_W=4.
- One sub-module: nibble_adder_slice, a purely combinational 4-bit ripple-carry adder with ports x[3:0], y[3:0], ci, s[3:0], co. Instantiated once.
- Everything else (FSM, operand registers, index, result registers) lives in the top module.

Test Plan:
- WIDTH=16, a=16'hFFFF, b=16'h0001, cin=0 -> 4 edges after start: sum=16'h0000, cout=1, overflow=0, done high exactly one cycle, busy high for 4 cycles.
- a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, cout=0, overflow=1. Then a=16'h8000, b=16'h8000 -> sum=16'h0000, cout=1, overflow=1.
- a=16'h1234, b=16'h4321, cin=1 -> sum=16'h5556, cout=0, overflow=0. sum holds its previous value for the whole busy window.
- start held high continuously with changing operands -> operands captured only on IDLE/DONE edges, results every 5 cycles; start pulses during RUN have no effect.
- rst asserted asynchronously mid-RUN (after 2 nibbles) -> outputs 0 immediately and no done pulse. The next start completes correctly, e.g. 16'h00F0+16'h0F10 = 16'h1000.
- Random regression, WIDTH=4 and WIDTH=32 builds, 1000 vectors -> {cout,sum} == a+b+cin; overflow matches the reference signed check.
